// File: rtl/expu_pkg.sv
// Shared types and limits for the exponential-unit stream controller.
package expu_pkg;

  typedef enum logic [1:0] {
    EXPU_IDLE,
    EXPU_RUN,
    EXPU_DRAIN,
    EXPU_DONE
  } expu_ctrl_state_e;

  localparam int EXPU_MAX_LATENCY = 8;

endpackage

// File: rtl/expu_stream_ctrl_if.sv
// Valid/ready handshake pair at both ends of the exponential row datapath.
interface expu_stream_ctrl_if;

  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid
  );

endinterface

// File: rtl/expu_valid_pipe.sv
// Enable-gated valid shift register that mirrors datapath occupancy.
// The whole pipe freezes only while the tail holds an undelivered result.
module expu_valid_pipe #(
  parameter int LATENCY = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  input  logic in_vld,
  input  logic out_rdy,
  output logic tail_vld,
  output logic enable
);

  logic [LATENCY-1:0] vld_q;

  assign tail_vld = vld_q[LATENCY-1];
  assign enable   = ~tail_vld | out_rdy;

  // Truncating the concatenation drops the old tail bit and works for LATENCY=1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
    end else if (clear) begin
      vld_q <= '0;
    end else if (enable) begin
      vld_q <= LATENCY'({vld_q, in_vld});
    end
  end

endmodule

// File: rtl/expu_stream_ctrl.sv
// Converts valid/ready streams into the exponential datapath's global enable/clear,
// counts accepted and delivered elements of a job and pulses done_o at the end.
module expu_stream_ctrl
  import expu_pkg::*;
#(
  parameter int LATENCY   = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  expu_stream_ctrl_if.slave    strm,
  output logic                 enable_o,
  output logic                 clear_o,
  output logic [CNT_WIDTH-1:0] in_cnt_o,
  output logic [CNT_WIDTH-1:0] out_cnt_o
);

  expu_ctrl_state_e     state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, in_cnt_q, out_cnt_q;
  logic [CNT_WIDTH-1:0] in_cnt_inc, out_cnt_inc;
  logic                 done_q;
  logic                 tail_vld, pipe_en;
  logic                 in_ready, accept, deliver, start_idle;

  assign start_idle  = (state_q == EXPU_IDLE) & start_i;
  assign clear_o     = clear_i | start_idle;
  assign in_ready    = (state_q == EXPU_RUN) & pipe_en & (in_cnt_q != len_q) & ~clear_i;
  assign accept      = strm.in_valid & in_ready;
  assign deliver     = tail_vld & strm.out_ready;
  assign in_cnt_inc  = in_cnt_q + 1'b1;
  assign out_cnt_inc = out_cnt_q + 1'b1;

  assign strm.in_ready  = in_ready;
  assign strm.out_valid = tail_vld;
  assign enable_o       = pipe_en;
  assign busy_o         = (state_q == EXPU_RUN) | (state_q == EXPU_DRAIN);
  assign done_o         = done_q;
  assign in_cnt_o       = in_cnt_q;
  assign out_cnt_o      = out_cnt_q;

  expu_valid_pipe #(
    .LATENCY (LATENCY)
  ) u_valid_pipe (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear    (clear_o),
    .in_vld   (accept),
    .out_rdy  (strm.out_ready),
    .tail_vld (tail_vld),
    .enable   (pipe_en)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      EXPU_IDLE:  if (start_i) state_d = (len_i == '0) ? EXPU_DONE : EXPU_RUN;
      EXPU_RUN:   if (accept && (in_cnt_inc == len_q)) state_d = EXPU_DRAIN;
      EXPU_DRAIN: if (deliver && (out_cnt_inc == len_q)) state_d = EXPU_DONE;
      EXPU_DONE:  state_d = EXPU_IDLE;
      default:    state_d = EXPU_IDLE;
    endcase
    if (clear_i) state_d = EXPU_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EXPU_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == EXPU_DONE) & ~clear_i;
    end
  end

  // Counters hold their final values after a job until the next start or clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else if (clear_i) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else if (start_idle) begin
      len_q     <= len_i;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      if (accept)  in_cnt_q  <= in_cnt_inc;
      if (deliver) out_cnt_q <= out_cnt_inc;
    end
  end

endmodule
